alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters (req0 = integer issue pipe, req1 = address/branch unit) using valid/ready handshakes and round-robin arbitration.
- Sequences one operation per cycle into the ALU and registers the result in a one-entry response buffer.
- Owns the architectural flag register (zero/less/greater), which it computes itself for CMP/TEST; the ALU's flag outputs are left unconnected.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter_rr_arbiter_2.sv | 35 +++
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encodings, widths and opcode classification helper for the
// ALU arbiter.
package alu_arbiter_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ALU_OP_BITS = 4;

  // Opcodes 8..15 are undefined and yield a zero result with flags untouched.
  typedef enum logic [ALU_OP_BITS-1:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_MOV  = 4'd2,
    ALU_OP_AND  = 4'd3,
    ALU_OP_OR   = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_CMP  = 4'd6,
    ALU_OP_TEST = 4'd7
  } alu_op_e;

  function automatic logic is_alu_op(input logic [ALU_OP_BITS-1:0] op);
    return op <= ALU_OP_XOR;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the ALU arbiter; the requesters, ALU
// and consumer sit on the master side, the arbiter on the slave side.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic                   req0_valid;
  logic                   req0_ready;
  logic [ALU_OP_BITS-1:0] req0_op;
  logic [DATA_WIDTH-1:0]  req0_a;
  logic [DATA_WIDTH-1:0]  req0_b;
  logic                   req1_valid;
  logic                   req1_ready;
  logic [ALU_OP_BITS-1:0] req1_op;
  logic [DATA_WIDTH-1:0]  req1_a;
  logic [DATA_WIDTH-1:0]  req1_b;
  logic [ALU_OP_BITS-1:0] alu_op;
  logic [DATA_WIDTH-1:0]  alu_data1;
  logic [DATA_WIDTH-1:0]  alu_data2;
  logic [DATA_WIDTH-1:0]  alu_result;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [DATA_WIDTH-1:0]  rsp_result;
  logic                   flag_zero;
  logic                   flag_less;
  logic                   flag_greater;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_op, alu_data1, alu_data2,
    input  rsp_valid, rsp_id, rsp_result, flag_zero, flag_less, flag_greater
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_op, alu_data1, alu_data2,
    output rsp_valid, rsp_id, rsp_result, flag_zero, flag_less, flag_greater
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: a tie goes to the requester that was not granted
// last; last_grant powers up pointing at requester 1 so requester 0 wins first.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic r_last_grant;

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (|grant) begin
      r_last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, buffers one result per
// cycle and owns the architectural zero/less/greater flags.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  logic                   w_can_issue;
  logic [1:0]             w_grant;
  logic                   w_xfer;
  logic [ALU_OP_BITS-1:0] w_op;
  logic [DATA_WIDTH-1:0]  w_a;
  logic [DATA_WIDTH-1:0]  w_b;

  logic                   r_rsp_valid;
  logic                   r_rsp_id;
  logic [DATA_WIDTH-1:0]  r_rsp_result;
  logic                   r_zero;
  logic                   r_less;
  logic                   r_greater;

  assign w_can_issue = !r_rsp_valid || bus.rsp_ready;

  // Gating with reset keeps both readies low during a reset cycle.
  rr_arbiter_2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .enable (w_can_issue && !reset),
    .grant  (w_grant)
  );

  assign w_xfer = |w_grant;

  always_comb begin
    w_op = ALU_OP_MOV;
    w_a  = '0;
    w_b  = '0;
    if (w_grant[0]) begin
      w_op = bus.req0_op;
      w_a  = bus.req0_a;
      w_b  = bus.req0_b;
    end else if (w_grant[1]) begin
      w_op = bus.req1_op;
      w_a  = bus.req1_a;
      w_b  = bus.req1_b;
    end
  end

  assign bus.req0_ready   = w_grant[0];
  assign bus.req1_ready   = w_grant[1];
  assign bus.alu_op       = w_op;
  assign bus.alu_data1    = w_a;
  assign bus.alu_data2    = w_b;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.flag_zero    = r_zero;
  assign bus.flag_less    = r_less;
  assign bus.flag_greater = r_greater;

  // Flags come from the full-width operands, never from the ALU result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_zero       <= 1'b0;
      r_less       <= 1'b0;
      r_greater    <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant[1];
      r_rsp_result <= is_alu_op(w_op) ? bus.alu_result : '0;
      case (w_op)
        ALU_OP_CMP: begin
          r_zero    <= (w_a == w_b);
          r_less    <= (w_a < w_b);
          r_greater <= (w_a > w_b);
        end
        ALU_OP_TEST: begin
          r_zero    <= ((w_a & w_b) == '0);
          r_less    <= 1'b0;
          r_greater <= 1'b0;
        end
        default: ;
      endcase
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side ALU; non-ALU opcodes return garbage the arbiter must discard.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_MOV: return a;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_data1, bus.alu_data2);

  // Reference model state, as it will be after the next rising edge.
  bit          model_ok = 1'b0;
  logic        m_valid, m_id, m_z, m_l, m_g, m_last;
  logic [31:0] m_result;

  always @(negedge clk) begin : compare
    logic        g0, g1, win;
    logic [3:0]  op;
    logic [31:0] a, b;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset && model_ok && (!m_valid || bus.rsp_ready)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else if (bus.req0_valid) begin
        g0 = 1'b1;
      end else if (bus.req1_valid) begin
        g1 = 1'b1;
      end
    end
    win = g1;
    op  = win ? bus.req1_op : bus.req0_op;
    a   = win ? bus.req1_a  : bus.req0_a;
    b   = win ? bus.req1_b  : bus.req0_b;
    check("req0_ready", bus.req0_ready, g0);
    check("req1_ready", bus.req1_ready, g1);
    if (g0 || g1) begin
      check("alu_op", bus.alu_op, op);
      check("alu_data1", bus.alu_data1, a);
      check("alu_data2", bus.alu_data2, b);
    end else begin
      check("alu_op_idle", bus.alu_op, ALU_OP_MOV);
      check("alu_data1_idle", bus.alu_data1, 32'd0);
      check("alu_data2_idle", bus.alu_data2, 32'd0);
    end
    if (model_ok) begin
      check("rsp_valid", bus.rsp_valid, m_valid);
      check("flag_zero", bus.flag_zero, m_z);
      check("flag_less", bus.flag_less, m_l);
      check("flag_greater", bus.flag_greater, m_g);
      if (m_valid) begin
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_result", bus.rsp_result, m_result);
      end
    end
    if (reset) begin
      model_ok = 1'b1;
      m_valid  = 1'b0;
      m_id     = 1'b0;
      m_result = 32'd0;
      m_z      = 1'b0;
      m_l      = 1'b0;
      m_g      = 1'b0;
      m_last   = 1'b1;
    end else if (g0 || g1) begin
      m_valid  = 1'b1;
      m_id     = win;
      m_last   = win;
      m_result = (op inside {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_MOV, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR})
                 ? alu_ref(op, a, b) : 32'd0;
      if (op == ALU_OP_CMP) begin
        m_z = (a == b);
        m_l = (a < b);
        m_g = (a > b);
      end else if (op == ALU_OP_TEST) begin
        m_z = ((a & b) == 32'd0);
        m_l = 1'b0;
        m_g = 1'b0;
      end
    end else if (bus.rsp_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = v;
    bus.req0_op    = op;
    bus.req0_a     = a;
    bus.req0_b     = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = v;
    bus.req1_op    = op;
    bus.req1_a     = a;
    bus.req1_b     = b;
  endtask

  // One requester-0 operation, then literal checks on the buffered result.
  task automatic op0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic z, input logic l, input logic g);
    set0(1'b1, op, a, b);
    tick();
    set0(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    at_neg();
    check("op_rsp_valid", bus.rsp_valid, 1'b1);
    check("op_rsp_result", bus.rsp_result, res);
    check("op_zero", bus.flag_zero, z);
    check("op_less", bus.flag_less, l);
    check("op_greater", bus.flag_greater, g);
    tick();
  endtask

  int exp_grant[4] = '{0, 1, 0, 1};

  initial begin
    set0(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    set1(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset then idle
    at_neg();
    check("idle_rsp_valid", bus.rsp_valid, 1'b0);
    check("idle_flags", {bus.flag_zero, bus.flag_less, bus.flag_greater}, 3'b000);
    check("idle_alu_op", bus.alu_op, ALU_OP_MOV);
    check("idle_alu_data", {bus.alu_data1, bus.alu_data2} == 64'd0, 1'b1);
    check("idle_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    tick();

    // Single request latency
    set0(1'b1, ALU_OP_ADD, 32'd5, 32'd7);
    at_neg();
    check("single_ready", bus.req0_ready, 1'b1);
    tick();
    set0(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    at_neg();
    check("single_valid", bus.rsp_valid, 1'b1);
    check("single_id", bus.rsp_id, 1'b0);
    check("single_result", bus.rsp_result, 32'd12);
    tick();

    // Requester 1 alone, so the following tie starts with requester 0
    set1(1'b1, ALU_OP_SUB, 32'd10, 32'd3);
    tick();
    set1(1'b0, ALU_OP_SUB, 32'd0, 32'd0);

    // Round-robin with no bubbles
    set0(1'b1, ALU_OP_ADD, 32'd100, 32'd1);
    set1(1'b1, ALU_OP_OR, 32'h0F00, 32'h00F0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("rr_ready0", bus.req0_ready, exp_grant[i] == 0);
      check("rr_ready1", bus.req1_ready, exp_grant[i] == 1);
      if (i > 0) begin
        check("rr_valid", bus.rsp_valid, 1'b1);
        check("rr_id", bus.rsp_id, exp_grant[i-1]);
      end
      tick();
    end
    set0(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    set1(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    at_neg();
    check("rr_last_id", bus.rsp_id, 1'b1);
    check("rr_last_result", bus.rsp_result, 32'h0FF0);
    tick();

    // Backpressure
    set0(1'b1, ALU_OP_SUB, 32'd9, 32'd4);
    tick();
    set0(1'b1, ALU_OP_ADD, 32'd1, 32'd1);
    set1(1'b1, ALU_OP_XOR, 32'hFF00, 32'h0FF0);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("bp_result", bus.rsp_result, 32'd5);
      check("bp_valid", bus.rsp_valid, 1'b1);
      check("bp_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      tick();
    end
    bus.rsp_ready = 1'b1;
    at_neg();
    check("bp_release_ready1", bus.req1_ready, 1'b1);
    check("bp_release_ready0", bus.req0_ready, 1'b0);
    tick();
    set0(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    set1(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    at_neg();
    check("bp_next_id", bus.rsp_id, 1'b1);
    check("bp_next_result", bus.rsp_result, 32'hF0F0);
    tick();

    // Flags
    op0(ALU_OP_CMP,  32'd3,    32'd3,         32'd0, 1'b1, 1'b0, 1'b0);
    op0(ALU_OP_CMP,  32'd2,    32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
    op0(ALU_OP_ADD,  32'd1,    32'd2,         32'd3, 1'b0, 1'b1, 1'b0);
    op0(4'hC,        32'd7,    32'd7,         32'd0, 1'b0, 1'b1, 1'b0);
    op0(ALU_OP_CMP,  32'd9,    32'd2,         32'd0, 1'b0, 1'b0, 1'b1);
    op0(ALU_OP_TEST, 32'hF0,   32'h0F,        32'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation
    set0(1'b1, ALU_OP_ADD, 32'd1, 32'd1);
    bus.rsp_ready = 1'b0;
    tick();
    set0(1'b1, ALU_OP_ADD, 32'd2, 32'd2);
    set1(1'b1, ALU_OP_SUB, 32'd8, 32'd1);
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    at_neg();
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b0;
    at_neg();
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_flags", {bus.flag_zero, bus.flag_less, bus.flag_greater}, 3'b000);
    check("rst_tie_ready0", bus.req0_ready, 1'b1);
    check("rst_tie_ready1", bus.req1_ready, 1'b0);
    tick();
    set0(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    set1(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      set0(($urandom % 4) != 0, 4'($urandom_range(0, 15)),
           ($urandom % 2) ? 32'($urandom_range(0, 3)) : $urandom,
           ($urandom % 2) ? 32'($urandom_range(0, 3)) : $urandom);
      set1(($urandom % 4) != 0, 4'($urandom_range(0, 9)),
           ($urandom % 2) ? 32'($urandom_range(0, 3)) : $urandom,
           ($urandom % 2) ? 32'($urandom_range(0, 3)) : $urandom);
      bus.rsp_ready = ($urandom % 3) != 0;
      tick();
    end
    reset = 1'b0;
    set0(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    set1(1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    at_neg();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
